regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources: A (ALU result) and M (memory load).
//  - Arbitrates between the two sources with valid/ready handshakes.
//  - Registers the winner onto rf_write_en/add/data for the regs block.
//  - Drops writes to the zero register.
//  - Flags read-after-write hazards: the regfile returns the old value when read and written on the same edge.
// PARAMETERS
//  DATA_W     64  width of write data
//  ADDR_W     5   register address width
//  ZERO_REG   31  hard-zero register; writes to it are acknowledged but never issued
//  STARVE_MAX 3   consecutive lost cycles after which A is forced to win (range 1..15)
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high reset
//  hold           in   1       pipeline stall; no grants while high
//  a_valid        in   1       ALU write request
//  a_addr         in   ADDR_W  ALU destination register
//  a_data         in   DATA_W  ALU result
//  a_ready        out  1       ALU request accepted this cycle
//  m_valid        in   1       load write request
//  m_addr         in   ADDR_W  load destination register
//  m_data         in   DATA_W  load data
//  m_ready        out  1       load request accepted this cycle
//  rf_write_en    out  1       regfile write enable (registered)
//  rf_write_add   out  ADDR_W  regfile write address (registered)
//  rf_write_data  out  DATA_W  regfile write data (registered)
//  rd_add1        in   ADDR_W  decode read address 1
//  rd_add2        in   ADDR_W  decode read address 2
//  hazard_1       out  1       pending write targets rd_add1 (combinational)
//  hazard_2       out  1       pending write targets rd_add2 (combinational)
//  zero_drop      out  1       one-cycle pulse: an accepted write targeted ZERO_REG
// BEHAVIOUR
//  Reset (async): all registered outputs 0, wait_cnt=0, FSM=PRIO_M; a_ready/m_ready are 0 during reset.
//  Handshake:
//   - Transfer occurs when valid&&ready on a rising edge.
//   - Requester holds valid, addr and data stable until ready.
//   - ready is a combinational function of valid, hold and FSM state; valid must not depend on ready.
//   - At most one of a_ready/m_ready is high per cycle; both are 0 when hold=1.
//  FSM states:
//   - PRIO_M: M wins when both are valid. In a cycle where A is valid and not granted, wait_cnt++.
//     When wait_cnt reaches STARVE_MAX, go to PRIO_A.
//   - PRIO_A: A wins when both are valid. After A's grant, wait_cnt=0 and return to PRIO_M.
//   - wait_cnt clears whenever A is granted or a_valid=0. A hold cycle neither increments nor clears wait_cnt.
//  Issue (latency 1):
//   - The accepted request appears on rf_write_* at the next edge, with rf_write_en high for exactly 1 cycle.
//   - When no transfer occurs, rf_write_en=0 and add/data keep their previous values.
//  Zero register:
//   - An accepted request with addr==ZERO_REG is acknowledged normally.
//   - rf_write_en stays 0 and zero_drop pulses high for 1 cycle instead.
//  Hazard:
//   - hazard_n = rf_write_en && rf_write_add==rd_add_n && rd_add_n!=ZERO_REG.
//   - Decode must hold/forward while the flag is high.
//  Throughput: one write per cycle sustained; the losing source waits with no buffering inside the block.
//  Reset mid-operation: any issued but not yet clocked write is lost (rf_write_en forced 0); requesters re-present the request.
//  Width: wait_cnt is 4 bits and saturates at STARVE_MAX; no other arithmetic.
// STRUCTURE
//  Package regfile_pkg: DATA_W, ADDR_W, ZERO_REG constants; wb_req_t typedef {addr, data}; arbiter FSM state enum.
//  Sub-module rf_hazard_cmp (address-compare plus zero-register mask), instantiated twice.
//  Everything else (FSM, wait counter, output register) stays flat in this module.
// TESTING
//  1. reset=1 while a_valid=1 (addr 5) -> a_ready=0, all outputs 0; after release, next edge gives rf_write_en=1, add=5.
//  2. a_valid only (addr 3, data 0xAA), then m_valid only (addr 4, data 0xBB) -> two consecutive 1-cycle writes, in order.
//  3. A and M both valid continuously, STARVE_MAX=3 -> grant pattern M,M,M,A,M,M,M,A; no cycle without a grant.
//  4. m_addr=31 accepted -> m_ready=1, rf_write_en stays 0, zero_drop pulses once.
//  5. write to reg 7 issued and rd_add1=7, rd_add2=31 -> hazard_1=1, hazard_2=0 in that cycle; both 0 next cycle.
//  6. hold=1 for 4 cycles with both valid -> no grants, wait_cnt unchanged; after hold drops, arbitration resumes from the prior state.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, writeback request record and arbiter state encoding
// for the register-file write-port arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PRIO_M = 1'b0,
    PRIO_A = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_hazard_cmp.sv
// Read-after-write hazard detect for one decode read port: the pending
// registered write matches the read address, ignoring the hard-zero register.
module rf_hazard_cmp
  import regfile_pkg::*;
(
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [ADDR_W-1:0] rd_add,
  output logic              hazard
);

  assign hazard = wr_en && (wr_add == rd_add) && (rd_add != ZERO_REG);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source (ALU / load) arbiter for the single register-file write port,
// with starvation guard for the ALU, zero-register drop and RAW hazard flags.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_add,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] rd_add1,
  input  logic [ADDR_W-1:0] rd_add2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic              zero_drop
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              rf_write_en_q, rf_write_en_d;
  logic [ADDR_W-1:0] rf_write_add_q, rf_write_add_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic              zero_drop_q, zero_drop_d;

  logic    a_grant, m_grant, transfer;
  wb_req_t win_req;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    a_grant    = 1'b0;
    m_grant    = 1'b0;
    if (!reset && !hold) begin
      if (a_valid && (!m_valid || state_q == PRIO_A)) a_grant = 1'b1;
      else if (m_valid)                               m_grant = 1'b1;

      if (a_grant || !a_valid) begin
        wait_cnt_d = 4'd0;
        state_d    = PRIO_M;
      end else begin
        if (wait_cnt_q < STARVE_LIM) wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_d == STARVE_LIM) state_d = PRIO_A;
      end
    end
  end

  assign a_ready  = a_grant;
  assign m_ready  = m_grant;
  assign transfer = a_grant || m_grant;
  assign win_req  = a_grant ? '{addr: a_addr, data: a_data}
                            : '{addr: m_addr, data: m_data};

  // Zero-register requests are acknowledged but only surface as zero_drop.
  always_comb begin
    rf_write_en_d   = transfer && (win_req.addr != ZERO_REG);
    zero_drop_d     = transfer && (win_req.addr == ZERO_REG);
    rf_write_add_d  = rf_write_add_q;
    rf_write_data_d = rf_write_data_q;
    if (rf_write_en_d) begin
      rf_write_add_d  = win_req.addr;
      rf_write_data_d = win_req.data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= PRIO_M;
      wait_cnt_q      <= 4'd0;
      rf_write_en_q   <= 1'b0;
      rf_write_add_q  <= '0;
      rf_write_data_q <= '0;
      zero_drop_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_write_add_q  <= rf_write_add_d;
      rf_write_data_q <= rf_write_data_d;
      zero_drop_q     <= zero_drop_d;
    end
  end

  assign rf_write_en   = rf_write_en_q;
  assign rf_write_add  = rf_write_add_q;
  assign rf_write_data = rf_write_data_q;
  assign zero_drop     = zero_drop_q;

  rf_hazard_cmp u_hazard_1 (
    .wr_en  (rf_write_en_q),
    .wr_add (rf_write_add_q),
    .rd_add (rd_add1),
    .hazard (hazard_1)
  );

  rf_hazard_cmp u_hazard_2 (
    .wr_en  (rf_write_en_q),
    .wr_add (rf_write_add_q),
    .rd_add (rd_add2),
    .hazard (hazard_2)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// randomized traffic against a behavioural model, and hand-written corner cases.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int STARVE = 3;

  logic              clock = 1'b0;
  logic              reset, hold;
  logic              a_valid, m_valid;
  logic [ADDR_W-1:0] a_addr, m_addr, rd_add1, rd_add2;
  logic [DATA_W-1:0] a_data, m_data;
  logic              a_ready, m_ready, rf_write_en, hazard_1, hazard_2, zero_drop;
  logic [ADDR_W-1:0] rf_write_add;
  logic [DATA_W-1:0] rf_write_data;

  regfile_write_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clock         (clock),
    .reset         (reset),
    .hold          (hold),
    .a_valid       (a_valid),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .m_valid       (m_valid),
    .m_addr        (m_addr),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rf_write_en   (rf_write_en),
    .rf_write_add  (rf_write_add),
    .rf_write_data (rf_write_data),
    .rd_add1       (rd_add1),
    .rd_add2       (rd_add2),
    .hazard_1      (hazard_1),
    .hazard_2      (hazard_2),
    .zero_drop     (zero_drop)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              hold, av, mv;
    logic [ADDR_W-1:0] aa, ma, rd1, rd2;
    logic [DATA_W-1:0] ad, md;
    logic              ar, mr, hz1, hz2, en, drop;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } vec_t;

  // Behavioural model: registered write-port image plus A's consecutive-loss streak.
  logic              mdl_en, mdl_drop;
  logic [ADDR_W-1:0] mdl_add;
  logic [DATA_W-1:0] mdl_data;
  int                lost;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int h, input int av, input int aa, input logic [63:0] ad,
                              input int mv, input int ma, input logic [63:0] md,
                              input int r1, input int r2,
                              input int ar, input int mr, input int hz1, input int hz2,
                              input int en, input int add, input logic [63:0] data, input int drop);
    vec_t v;
    v.hold = h[0];  v.av = av[0]; v.aa = aa[4:0]; v.ad = ad;
    v.mv = mv[0];   v.ma = ma[4:0]; v.md = md;
    v.rd1 = r1[4:0]; v.rd2 = r2[4:0];
    v.ar = ar[0]; v.mr = mr[0]; v.hz1 = hz1[0]; v.hz2 = hz2[0];
    v.en = en[0]; v.add = add[4:0]; v.data = data; v.drop = drop[0];
    return v;
  endfunction

  // Entered just after a rising edge; one clock cycle per vector.
  task automatic run_vec(input vec_t v, input string tag);
    hold = v.hold; a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    m_valid = v.mv; m_addr = v.ma; m_data = v.md; rd_add1 = v.rd1; rd_add2 = v.rd2;
    @(negedge clock);
    check({tag, " a_ready"},  64'(a_ready),  64'(v.ar));
    check({tag, " m_ready"},  64'(m_ready),  64'(v.mr));
    check({tag, " hazard_1"}, 64'(hazard_1), 64'(v.hz1));
    check({tag, " hazard_2"}, 64'(hazard_2), 64'(v.hz2));
    @(posedge clock);
    #1;
    check({tag, " rf_write_en"},   64'(rf_write_en),  64'(v.en));
    check({tag, " rf_write_add"},  64'(rf_write_add), 64'(v.add));
    check({tag, " rf_write_data"}, rf_write_data,     v.data);
    check({tag, " zero_drop"},     64'(zero_drop),    64'(v.drop));
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
    a_addr = '0; m_addr = '0; a_data = '0; m_data = '0; rd_add1 = '0; rd_add2 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    mdl_en = 1'b0; mdl_drop = 1'b0; mdl_add = '0; mdl_data = '0; lost = 0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return ZERO_REG;
    return 5'($urandom_range(0, 31));
  endfunction

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic pa, pm, h, ga, gm;
    logic [ADDR_W-1:0] paa, pma, r1, r2, waddr;
    logic [DATA_W-1:0] pad, pmd;

    tbl[0]  = mk(0, 1, 3, 64'hAA, 0, 0, 64'h0,   0, 0,   1, 0, 0, 0, 1, 3, 64'hAA, 0);
    tbl[1]  = mk(0, 0, 0, 64'h0,  1, 4, 64'hBB,  3, 0,   0, 1, 1, 0, 1, 4, 64'hBB, 0);
    tbl[2]  = mk(0, 0, 0, 64'h0,  0, 0, 64'h0,   4, 4,   0, 0, 1, 1, 0, 4, 64'hBB, 0);
    tbl[3]  = mk(0, 0, 0, 64'h0,  0, 0, 64'h0,   4, 0,   0, 0, 0, 0, 0, 4, 64'hBB, 0);
    tbl[4]  = mk(0, 1, 1, 64'h11, 1, 2, 64'h22,  0, 0,   0, 1, 0, 0, 1, 2, 64'h22, 0);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(0, 1, 1, 64'h11, 1, 2, 64'h22,  0, 0,   1, 0, 0, 0, 1, 1, 64'h11, 0);
    tbl[8]  = tbl[4];
    tbl[9]  = tbl[4];
    tbl[10] = tbl[4];
    tbl[11] = tbl[7];
    tbl[12] = mk(0, 0, 0, 64'h0,  1, 31, 64'hCC, 0, 0,   0, 1, 0, 0, 0, 1, 64'h11, 1);
    tbl[13] = mk(0, 0, 0, 64'h0,  0, 0, 64'h0,   0, 0,   0, 0, 0, 0, 0, 1, 64'h11, 0);
    tbl[14] = mk(0, 1, 7, 64'h77, 0, 0, 64'h0,   0, 0,   1, 0, 0, 0, 1, 7, 64'h77, 0);
    tbl[15] = mk(0, 0, 0, 64'h0,  0, 0, 64'h0,   7, 31,  0, 0, 1, 0, 0, 7, 64'h77, 0);
    tbl[16] = mk(0, 0, 0, 64'h0,  0, 0, 64'h0,   7, 31,  0, 0, 0, 0, 0, 7, 64'h77, 0);
    tbl[17] = mk(0, 1, 31, 64'hEE, 0, 0, 64'h0,  0, 0,   1, 0, 0, 0, 0, 7, 64'h77, 1);
    tbl[18] = mk(1, 1, 9, 64'h99, 1, 10, 64'hA0, 0, 0,   0, 0, 0, 0, 0, 7, 64'h77, 0);

    do_reset();
    check("reset rf_write_en", 64'(rf_write_en), 64'd0);
    check("reset zero_drop",   64'(zero_drop),   64'd0);

    for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Randomized traffic; each requester keeps its request stable until accepted.
    do_reset();
    pa = 1'b0; pm = 1'b0; paa = '0; pma = '0; pad = '0; pmd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; paa = rand_addr(); pad = {$urandom(), $urandom()};
      end
      if (!pm && $urandom_range(0, 2) != 0) begin
        pm = 1'b1; pma = rand_addr(); pmd = {$urandom(), $urandom()};
      end
      h  = ($urandom_range(0, 5) == 0);
      r1 = rand_addr();
      r2 = rand_addr();

      ga = 1'b0; gm = 1'b0;
      if (!h) begin
        if (pa && (!pm || lost >= STARVE)) ga = 1'b1;
        else if (pm)                       gm = 1'b1;
      end

      v = mk(int'(h), int'(pa), int'(paa), pad, int'(pm), int'(pma), pmd, int'(r1), int'(r2),
             int'(ga), int'(gm),
             int'(mdl_en && mdl_add == r1 && r1 != ZERO_REG),
             int'(mdl_en && mdl_add == r2 && r2 != ZERO_REG),
             0, 0, 64'h0, 0);

      mdl_en = 1'b0; mdl_drop = 1'b0;
      if (ga || gm) begin
        waddr = ga ? paa : pma;
        if (waddr == ZERO_REG) mdl_drop = 1'b1;
        else begin
          mdl_en = 1'b1; mdl_add = waddr; mdl_data = ga ? pad : pmd;
        end
      end
      if (!h) begin
        if (!pa || ga)          lost = 0;
        else if (lost < STARVE) lost++;
      end
      v.en = mdl_en; v.add = mdl_add; v.data = mdl_data; v.drop = mdl_drop;

      run_vec(v, "rand");
      if (ga) pa = 1'b0;
      if (gm) pm = 1'b0;
    end

    // Hold for four cycles mid-streak: the loss count survives the stall.
    do_reset();
    v = mk(0, 1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 0, 1, 0, 0, 1, 2, 64'h22, 0);
    run_vec(v, "hold pre1");
    run_vec(v, "hold pre2");
    for (int i = 0; i < 4; i++)
      run_vec(mk(1, 1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 0, 0, 0, 0, 0, 2, 64'h22, 0),
              $sformatf("hold cyc%0d", i));
    run_vec(v, "hold post M");
    run_vec(mk(0, 1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 1, 0, 0, 0, 1, 1, 64'h11, 0), "hold post A");
    run_vec(v, "hold post M2");

    // Asynchronous reset while a write is issued and A is requesting.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h55; m_valid = 1'b0; hold = 1'b0;
    reset = 1'b1;
    #1;
    check("rst a_ready",       64'(a_ready),     64'd0);
    check("rst m_ready",       64'(m_ready),     64'd0);
    check("rst rf_write_en",   64'(rf_write_en), 64'd0);
    check("rst rf_write_add",  64'(rf_write_add), 64'd0);
    check("rst rf_write_data", rf_write_data,    64'd0);
    @(posedge clock);
    #1;
    check("rst edge rf_write_en", 64'(rf_write_en), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post-rst a_ready", 64'(a_ready), 64'd1);
    @(posedge clock);
    #1;
    check("post-rst rf_write_en",   64'(rf_write_en),  64'd1);
    check("post-rst rf_write_add",  64'(rf_write_add), 64'd5);
    check("post-rst rf_write_data", rf_write_data,     64'h55);
    a_valid = 1'b0;
    @(posedge clock);
    #1;
    check("post-rst single pulse", 64'(rf_write_en), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
